// File: rtl/ddi_pkg.sv
// Shared encodings for the DDI phase sequencer: state codes, direction constants
// and the phase-index width helper.
package ddi_pkg;

    typedef enum logic [3:0] {
        ST_ALL_RED     = 4'd0,
        ST_GREEN       = 4'd1,
        ST_YELLOW      = 4'd2,
        ST_PRIO_GREEN  = 4'd3,
        ST_PRIO_YELLOW = 4'd4,
        ST_MAINT       = 4'd5
    } ddi_state_e;

    localparam logic DIR_EAST = 1'b0;
    localparam logic DIR_WEST = 1'b1;

    function automatic int ph_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ddi_dwell_timer.sv
// Down-counting dwell timer shared by every timed state of the sequencer.
// A load wins over the decrement; the count holds at zero.
module ddi_dwell_timer
    import ddi_pkg::*;
#(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= RST_VAL;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/ddi_phase_sequencer.sv
// DDI phase sequencer: round-robin normal phases, fair east/west priority service
// and maintenance flash. Early green truncation is built only with DDI_PREEMPT_EN.
module ddi_phase_sequencer
    import ddi_pkg::*;
#(
    parameter int NUM_PHASES    = 3,
    parameter int CNT_W         = 8,
    parameter int GREEN_CYC     = 16,
    parameter int YELLOW_CYC    = 4,
    parameter int ALLRED_CYC    = 2,
    parameter int PRIO_CYC      = 8,
    parameter int FLASH_CYC     = 4,
    parameter int MIN_GREEN_CYC = 6
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 maint,
    input  logic [1:0]                           prio_req,
    output logic [1:0]                           prio_ack,
    output logic [3:0]                           state,
    output logic [ph_width(NUM_PHASES)-1:0]      phase,
    output logic                                 prio_dir,
    output logic                                 flash,
    output logic [CNT_W-1:0]                     timer
);

    localparam int PH_W = ph_width(NUM_PHASES);

    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] PRIO_LD   = CNT_W'(PRIO_CYC - 1);
    localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_CYC - 1);
    localparam logic [PH_W-1:0]  LAST_PH   = PH_W'(NUM_PHASES - 1);

`ifdef DDI_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif
    // Remaining-count at which MIN_GREEN_CYC green cycles have elapsed.
    localparam int TRUNC_AT = (GREEN_CYC > MIN_GREEN_CYC) ? GREEN_CYC - MIN_GREEN_CYC : 0;

    ddi_state_e        state_q;
    logic [PH_W-1:0]   phase_q;
    logic              prio_dir_q;
    logic              last_dir_q;
    logic              served_q;
    logic              flash_q;
    logic [1:0]        prio_ack_q;

    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic [CNT_W-1:0]  tmr_cnt;
    logic              tmr_zero;

    logic              prio_go;
    logic              dir_pick;
    logic              grn_end;

    assign prio_go  = !served_q && (prio_req != 2'b00);
    assign dir_pick = (prio_req == 2'b11) ? ~last_dir_q : prio_req[1];
    assign grn_end  = tmr_zero ||
                      (PREEMPT && (prio_req != 2'b00) && (tmr_cnt <= CNT_W'(TRUNC_AT)));

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = ALLRED_LD;
        if (maint && (state_q != ST_MAINT)) begin
            tmr_load = 1'b1;
            tmr_val  = FLASH_LD;
        end else begin
            case (state_q)
                ST_MAINT: begin
                    if (!maint) begin
                        tmr_load = 1'b1;
                        tmr_val  = ALLRED_LD;
                    end else if (tmr_zero) begin
                        tmr_load = 1'b1;
                        tmr_val  = FLASH_LD;
                    end
                end
                ST_ALL_RED: begin
                    tmr_load = tmr_zero;
                    tmr_val  = prio_go ? PRIO_LD : GREEN_LD;
                end
                ST_GREEN: begin
                    tmr_load = grn_end;
                    tmr_val  = YELLOW_LD;
                end
                ST_YELLOW: begin
                    tmr_load = tmr_zero;
                    tmr_val  = ALLRED_LD;
                end
                ST_PRIO_GREEN: begin
                    tmr_load = tmr_zero;
                    tmr_val  = YELLOW_LD;
                end
                ST_PRIO_YELLOW: begin
                    tmr_load = tmr_zero;
                    tmr_val  = ALLRED_LD;
                end
                default: begin
                    tmr_load = 1'b1;
                    tmr_val  = ALLRED_LD;
                end
            endcase
        end
    end

    ddi_dwell_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (ALLRED_LD)
    ) u_dwell (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (1'b1),
        .count    (tmr_cnt),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ALL_RED;
            phase_q    <= LAST_PH;
            prio_dir_q <= DIR_WEST;
            last_dir_q <= DIR_WEST;
            served_q   <= 1'b0;
            flash_q    <= 1'b0;
            prio_ack_q <= 2'b00;
        end else begin
            prio_ack_q <= 2'b00;
            if (maint && (state_q != ST_MAINT)) begin
                state_q <= ST_MAINT;
                flash_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_MAINT: begin
                        if (!maint) begin
                            // Restart the cycle cleanly: next green is phase 0, no prio first.
                            state_q  <= ST_ALL_RED;
                            flash_q  <= 1'b0;
                            phase_q  <= LAST_PH;
                            served_q <= 1'b1;
                        end else if (tmr_zero) begin
                            flash_q <= ~flash_q;
                        end
                    end
                    ST_ALL_RED: begin
                        if (tmr_zero) begin
                            if (prio_go) begin
                                state_q    <= ST_PRIO_GREEN;
                                prio_dir_q <= dir_pick;
                                last_dir_q <= dir_pick;
                                prio_ack_q <= dir_pick ? 2'b10 : 2'b01;
                            end else begin
                                state_q <= ST_GREEN;
                                phase_q <= (phase_q == LAST_PH) ? '0 : phase_q + 1'b1;
                            end
                        end
                    end
                    ST_GREEN: begin
                        if (grn_end) state_q <= ST_YELLOW;
                    end
                    ST_YELLOW: begin
                        if (tmr_zero) begin
                            state_q  <= ST_ALL_RED;
                            served_q <= 1'b0;
                        end
                    end
                    ST_PRIO_GREEN: begin
                        if (tmr_zero) state_q <= ST_PRIO_YELLOW;
                    end
                    ST_PRIO_YELLOW: begin
                        if (tmr_zero) begin
                            state_q  <= ST_ALL_RED;
                            served_q <= 1'b1;
                        end
                    end
                    default: state_q <= ST_ALL_RED;
                endcase
            end
        end
    end

    assign state    = state_q;
    assign phase    = phase_q;
    assign prio_dir = prio_dir_q;
    assign flash    = flash_q;
    assign prio_ack = prio_ack_q;
    assign timer    = tmr_cnt;

endmodule
